// File: rtl/qracc_sram_arbiter.sv
// Two-requester round-robin arbiter for the QRAcc digital SRAM port.
// Holds the grant across SRAM stalls and routes read data back by an in-order requester tag FIFO.
module qracc_sram_arbiter #(
    parameter int NumRows        = 128,
    parameter int NumCols        = 32,
    parameter int MaxOutstanding = 4,
    localparam int AddrBits      = $clog2(NumRows)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [1:0]            req_valid_i,
    input  logic [1:0]            req_wr_i,
    input  logic [2*AddrBits-1:0] req_addr_i,
    input  logic [2*NumCols-1:0]  req_wr_data_i,
    output logic [1:0]            req_ready_o,
    output logic [1:0]            req_rd_valid_o,
    output logic [NumCols-1:0]    req_rd_data_o,
    output logic                  sram_rq_valid_o,
    output logic                  sram_rq_wr_o,
    output logic [AddrBits-1:0]   sram_addr_o,
    output logic [NumCols-1:0]    sram_wr_data_o,
    input  logic                  sram_rq_ready_i,
    input  logic                  sram_rd_valid_i,
    input  logic [NumCols-1:0]    sram_rd_data_i,
    output logic                  err_o
);

    localparam int PtrBits = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntBits = PtrBits + 1;

    logic               prio_ptr;
    logic               lock;
    logic               locked_id;
    logic [PtrBits-1:0] wr_ptr;
    logic [PtrBits-1:0] rd_ptr;
    logic [CntBits-1:0] count;
    logic               tag_mem [MaxOutstanding];

    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         eligible;
    logic               grant_valid;
    logic               grant_id;
    logic               active;
    logic               handshake;
    logic               push;
    logic               pop;
    logic               head_id;

    // Fullness comes from the registered count, so a same-cycle pop never unblocks a read.
    assign fifo_full  = (count == CntBits'(MaxOutstanding));
    assign fifo_empty = (count == '0);
    assign eligible   = req_valid_i & (req_wr_i | {2{~fifo_full}});

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (lock) begin
            grant_valid = 1'b1;
            grant_id    = locked_id;
        end else if (eligible[0] && eligible[1]) begin
            grant_valid = 1'b1;
            grant_id    = prio_ptr;
        end else if (eligible[0]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (eligible[1]) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    // Everything combinational is forced quiet while reset is asserted.
    assign active    = grant_valid & nrst;
    assign handshake = active & sram_rq_ready_i;
    assign push      = handshake & ~sram_rq_wr_o;
    assign pop       = nrst & sram_rd_valid_i & ~fifo_empty;
    assign head_id   = tag_mem[rd_ptr];

    always_comb begin
        sram_rq_valid_o = active;
        sram_rq_wr_o    = 1'b0;
        sram_addr_o     = '0;
        sram_wr_data_o  = '0;
        req_ready_o     = 2'b00;
        if (active) begin
            sram_rq_wr_o   = req_wr_i[grant_id];
            sram_addr_o    = grant_id ? req_addr_i[2*AddrBits-1:AddrBits] : req_addr_i[AddrBits-1:0];
            sram_wr_data_o = grant_id ? req_wr_data_i[2*NumCols-1:NumCols] : req_wr_data_i[NumCols-1:0];
            if (sram_rq_ready_i) begin
                req_ready_o = grant_id ? 2'b10 : 2'b01;
            end
        end
    end

    always_comb begin
        req_rd_valid_o = 2'b00;
        req_rd_data_o  = '0;
        if (pop) begin
            req_rd_valid_o = head_id ? 2'b10 : 2'b01;
            req_rd_data_o  = sram_rd_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prio_ptr  <= 1'b0;
            lock      <= 1'b0;
            locked_id <= 1'b0;
        end else begin
            if (handshake) begin
                lock     <= 1'b0;
                prio_ptr <= ~grant_id;
            end else if (active) begin
                lock      <= 1'b1;
                locked_id <= grant_id;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrBits'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrBits'(1);
            end
            if (push && !pop) begin
                count <= count + CntBits'(1);
            end else if (pop && !push) begin
                count <= count - CntBits'(1);
            end
            if (sram_rd_valid_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    // NOTE: tag storage is not reset; entries are only read below the registered count, which is.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_id;
        end
    end

endmodule
